// File: rtl/ibus_mem_responder_pkg.sv
// Shared instruction-bus types, responder states and constants.
// Imported by the responder, its store and the fetch side.
package ibus_mem_responder_pkg;

  localparam logic [31:0] PCINIT   = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } ibus_resp_state_t;

  // Out of the mapped window (32-bit wrap) or not word aligned.
  function automatic logic ibus_bad_addr(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] span
  );
    logic [31:0] off;
    off = addr - base;
    return (off >= span) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ibus_mem_responder_mem_array.sv
// DEPTH x 32 instruction store: registered read with enable, one write.
// Ports: clk, i_re/i_raddr/o_rdata read, i_we/i_waddr/i_wdata write.
module ibus_mem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Same-edge read and write: the read sees the old word.
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ibus_mem_responder.sv
// Instruction-bus responder: word store with LATENCY wait states.
// Ports: clk, rst(n), ireq/iresp bus, load_* preload, fault, busy.
module ibus_mem_responder
  import ibus_mem_responder_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [31:0] BASE    = PCINIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  ibus_req_t                ireq,
  output ibus_resp_t               iresp,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [31:0]              load_data,
  output logic                     fault,
  output logic                     busy
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);
  localparam logic [3:0]  LAT  = 4'(LATENCY);

  ibus_resp_state_t r_state;
  ibus_resp_state_t w_next;
  logic [3:0]       r_cnt;
  logic [31:0]      r_addr;
  logic             r_fault;
  logic [31:0]      r_last;

  logic             w_accept;
  logic             w_in_fault;
  logic             w_re;
  logic [AW-1:0]    w_ridx;
  logic [31:0]      w_rdata;
  logic [31:0]      w_rsp_data;

  assign w_accept   = rst && (r_state == IDLE) && ireq.valid;
  assign w_in_fault = ibus_bad_addr(ireq.addr, BASE, SPAN);
  assign w_rsp_data = r_fault ? NOP_INST : w_rdata;

  always_comb begin
    w_next = r_state;
    w_re   = 1'b0;
    w_ridx = AW'((r_addr - BASE) >> 2);
    unique case (r_state)
      IDLE: begin
        if (ireq.valid) begin
          w_next = (LAT == 4'd0) ? RESP : WAIT;
          // Zero wait states: read straight from the bus address.
          if (LAT == 4'd0) begin
            w_re   = !w_in_fault;
            w_ridx = AW'((ireq.addr - BASE) >> 2);
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next = RESP;
          w_re   = !r_fault;
        end
      end
      RESP: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_fault <= 1'b0;
      r_last  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= ireq.addr;
        r_fault <= w_in_fault;
        r_cnt   <= LAT;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Keep the last returned word on the bus between responses.
      if (r_state == RESP) r_last <= w_rsp_data;
    end
  end

  ibus_mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_re    (w_re),
    .i_raddr (w_ridx),
    .o_rdata (w_rdata),
    .i_we    (load_en),
    .i_waddr (load_idx),
    .i_wdata (load_data)
  );

  assign iresp.addr_ok = w_accept;
  assign iresp.data_ok = (r_state == RESP);
  assign iresp.data    = (r_state == RESP) ? w_rsp_data : r_last;
  assign fault         = (r_state == RESP) && r_fault;
  assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Bench: two responders (LATENCY 2 and 0) against a timing/store model.
// Directed scenarios first, then randomized traffic with preloads.
module tb_ibus_mem_responder;
  import ibus_mem_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam logic [31:0] BASE = PCINIT;

  logic          clk = 1'b0;
  logic          rstn [2];
  ibus_req_t     ireq [2];
  ibus_resp_t    iresp [2];
  logic          load_en [2];
  logic [AW-1:0] load_idx [2];
  logic [31:0]   load_data [2];
  logic          fault [2];
  logic          busy [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rnd_on = 0;

  logic [31:0] m_mem [2][DEPTH];
  bit          pend [2];
  int          tacc [2];
  logic        efault [2];
  logic [AW-1:0] eidx [2];
  logic [31:0] edata [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ibus_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE(BASE)) dut2 (
    .clk(clk), .rst(rstn[0]), .ireq(ireq[0]), .iresp(iresp[0]),
    .load_en(load_en[0]), .load_idx(load_idx[0]),
    .load_data(load_data[0]), .fault(fault[0]), .busy(busy[0]));

  ibus_mem_responder #(.DEPTH(DEPTH), .LATENCY(0), .BASE(BASE)) dut0 (
    .clk(clk), .rst(rstn[1]), .ireq(ireq[1]), .iresp(iresp[1]),
    .load_en(load_en[1]), .load_idx(load_idx[1]),
    .load_data(load_data[1]), .fault(fault[1]), .busy(busy[1]));

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc=%0d got=%h want=%h",
               nm, k, cyc, act, exp);
    end
  endtask

  // Model: accept at T -> data_ok at T+1+L, busy over T+1..T+1+L,
  // store sampled before the writes of the edge closing cycle T+L.
  task automatic model_step(input int k);
    int lat;
    bit dok, bsy, aok;
    logic [31:0] off;
    lat = (k == 0) ? 2 : 0;
    if (!rstn[k]) begin
      chk("rst_aok", k, {31'd0, iresp[k].addr_ok}, 32'd0);
      chk("rst_dok", k, {31'd0, iresp[k].data_ok}, 32'd0);
      chk("rst_data", k, iresp[k].data, 32'd0);
      chk("rst_fault", k, {31'd0, fault[k]}, 32'd0);
      chk("rst_busy", k, {31'd0, busy[k]}, 32'd0);
      pend[k] = 0;
    end else begin
      dok = pend[k] && (cyc == tacc[k] + 1 + lat);
      bsy = pend[k] && (cyc > tacc[k]) && (cyc <= tacc[k] + 1 + lat);
      aok = ireq[k].valid && !bsy;
      chk("addr_ok", k, {31'd0, iresp[k].addr_ok}, {31'd0, aok});
      chk("data_ok", k, {31'd0, iresp[k].data_ok}, {31'd0, dok});
      chk("busy", k, {31'd0, busy[k]}, {31'd0, bsy});
      if (dok) begin
        chk("data", k, iresp[k].data, edata[k]);
        chk("fault", k, {31'd0, fault[k]}, {31'd0, efault[k]});
        pend[k] = 0;
      end
      if (aok) begin
        pend[k] = 1;
        tacc[k] = cyc;
        off = ireq[k].addr - BASE;
        efault[k] = (off >= 32'(DEPTH * 4)) || (ireq[k].addr[1:0] != 2'b00);
        eidx[k] = off[AW+1:2];
      end
      if (pend[k] && cyc == tacc[k] + lat)
        edata[k] = efault[k] ? NOP_INST : m_mem[k][eidx[k]];
    end
    if (load_en[k]) m_mem[k][load_idx[k]] = load_data[k];
  endtask

  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic step(input int k);
    @(posedge clk);
    #1;
    load_en[k] = 1'b0;
    if (rnd_on && $urandom_range(0, 3) == 0) begin
      load_en[k]   = 1'b1;
      load_idx[k]  = AW'($urandom_range(0, 15));
      load_data[k] = $urandom;
    end
  endtask

  task automatic preload(input int k, input int idx, input logic [31:0] d);
    load_en[k]   = 1'b1;
    load_idx[k]  = AW'(idx);
    load_data[k] = d;
    step(k);
  endtask

  task automatic wait_aok(input int k, output int t);
    t = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (iresp[k].addr_ok) begin
        t = cyc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_aok inst%0d timed out", k);
  endtask

  task automatic wait_dok(input int k, output int t);
    t = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (iresp[k].data_ok) begin
        t = cyc;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL wait_dok inst%0d timed out", k);
  endtask

  function automatic logic [31:0] rnd_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)
      return BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
    if (r == 1)
      return BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
    if (r == 2)
      return BASE - 32'($urandom_range(1, 16) * 4);
    return BASE + 32'($urandom_range(0, 15) * 4);
  endfunction

  task automatic rnd_phase(input int k, input int ntr);
    int ta, td;
    for (int i = 0; i < ntr; i++) begin
      ireq[k].valid = 1'b1;
      ireq[k].addr  = rnd_addr();
      wait_aok(k, ta);
      step(k);
      case ($urandom_range(0, 2))
        0: ireq[k].valid = 1'b0;
        1: ireq[k].addr = $urandom;
        default: ;
      endcase
      wait_dok(k, td);
      step(k);
      if ($urandom_range(0, 1) == 0) begin
        ireq[k].valid = 1'b0;
        for (int j = 0; j < $urandom_range(0, 2); j++) step(k);
      end
    end
    ireq[k].valid = 1'b0;
    step(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, td, t1, t2, t3;
    logic [31:0] w;
    for (int k = 0; k < 2; k++) begin
      rstn[k] = 1'b0;
      ireq[k] = '0;
      load_en[k] = 1'b0;
      load_idx[k] = '0;
      load_data[k] = '0;
      pend[k] = 0;
      tacc[k] = 0;
      efault[k] = 1'b0;
      eidx[k] = '0;
      edata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        case (i)
          0: w = 32'h0010_0093;
          1: w = 32'h0020_0113;
          2: w = 32'h0030_0193;
          5: w = 32'h0050_0293;
          default: w = 32'hC0DE_0000 | 32'(i);
        endcase
        preload(k, i, w);
      end

    // single request, LATENCY 2
    ireq[0].valid = 1'b1;
    ireq[0].addr  = BASE;
    wait_aok(0, ta);
    @(negedge clk);
    chk("t1_busy", 0, {31'd0, busy[0]}, 32'd1);
    chk("t1_nodok", 0, {31'd0, iresp[0].data_ok}, 32'd0);
    @(negedge clk);
    chk("t2_nodok", 0, {31'd0, iresp[0].data_ok}, 32'd0);
    @(negedge clk);
    chk("t3_dok", 0, {31'd0, iresp[0].data_ok}, 32'd1);
    chk("t3_data", 0, iresp[0].data, 32'h0010_0093);
    chk("t3_fault", 0, {31'd0, fault[0]}, 32'd0);
    step(0);
    ireq[0].valid = 1'b0;
    step(0);

    // back-to-back with valid held
    ireq[0].valid = 1'b1;
    ireq[0].addr  = BASE;
    wait_dok(0, t1);
    chk("b2b_a", 0, iresp[0].data, 32'h0010_0093);
    step(0);
    ireq[0].addr = BASE + 32'd4;
    wait_dok(0, t2);
    chk("b2b_b", 0, iresp[0].data, 32'h0020_0113);
    chk("b2b_gap1", 0, 32'(t2 - t1), 32'd4);
    step(0);
    ireq[0].addr = BASE + 32'd8;
    wait_dok(0, t3);
    chk("b2b_c", 0, iresp[0].data, 32'h0030_0193);
    chk("b2b_gap2", 0, 32'(t3 - t2), 32'd4);
    step(0);

    // misaligned and just past the window
    ireq[0].addr = BASE + 32'd2;
    wait_dok(0, td);
    chk("mis_data", 0, iresp[0].data, NOP_INST);
    chk("mis_fault", 0, {31'd0, fault[0]}, 32'd1);
    step(0);
    ireq[0].addr = BASE + 32'(DEPTH * 4);
    wait_dok(0, td);
    chk("oor_data", 0, iresp[0].data, NOP_INST);
    chk("oor_fault", 0, {31'd0, fault[0]}, 32'd1);
    step(0);
    ireq[0].valid = 1'b0;
    step(0);

    // reset while in WAIT
    ireq[0].valid = 1'b1;
    ireq[0].addr  = BASE + 32'd4;
    wait_aok(0, ta);
    step(0);
    ireq[0].valid = 1'b0;
    #2;
    rstn[0] = 1'b0;
    #1;
    chk("arst_busy", 0, {31'd0, busy[0]}, 32'd0);
    chk("arst_dok", 0, {31'd0, iresp[0].data_ok}, 32'd0);
    chk("arst_data", 0, iresp[0].data, 32'd0);
    step(0);
    step(0);
    rstn[0] = 1'b1;
    step(0);
    ireq[0].valid = 1'b1;
    ireq[0].addr  = BASE + 32'd4;
    wait_dok(0, td);
    chk("post_rst", 0, iresp[0].data, 32'h0020_0113);
    step(0);
    ireq[0].valid = 1'b0;
    step(0);

    // write on the read edge of word 5
    ireq[0].valid = 1'b1;
    ireq[0].addr  = BASE + 32'd20;
    wait_aok(0, ta);
    step(0);
    step(0);
    load_en[0]   = 1'b1;
    load_idx[0]  = AW'(5);
    load_data[0] = 32'hDEAD_BEEF;
    wait_dok(0, td);
    chk("rbw_old", 0, iresp[0].data, 32'h0050_0293);
    chk("rbw_lat", 0, 32'(td - ta), 32'd3);
    step(0);
    wait_dok(0, td);
    chk("rbw_new", 0, iresp[0].data, 32'hDEAD_BEEF);
    step(0);
    ireq[0].valid = 1'b0;
    step(0);

    // LATENCY 0
    ireq[1].valid = 1'b1;
    ireq[1].addr  = BASE + 32'd4;
    wait_aok(1, ta);
    @(negedge clk);
    chk("l0_dok", 1, {31'd0, iresp[1].data_ok}, 32'd1);
    chk("l0_noaok", 1, {31'd0, iresp[1].addr_ok}, 32'd0);
    chk("l0_data", 1, iresp[1].data, 32'h0020_0113);
    step(1);
    ireq[1].addr = BASE + 32'd8;
    @(negedge clk);
    chk("l0_reacc", 1, {31'd0, iresp[1].addr_ok}, 32'd1);
    @(negedge clk);
    chk("l0_data2", 1, iresp[1].data, 32'h0030_0193);
    step(1);
    ireq[1].valid = 1'b0;
    step(1);

    rnd_on = 1;
    rnd_phase(0, 150);
    rnd_phase(1, 150);
    rnd_on = 0;
    step(0);
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
